// File: rtl/serial_add_ctrl_if.sv
// serial_add_ctrl_if: request/result bundle for the bit-serial adder.
interface serial_add_ctrl_if #(parameter int WIDTH = 8);
  logic start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic ci_in;
  logic busy;
  logic done;
  logic [WIDTH-1:0] sum;
  logic cry;
  modport master (output start, a_in, b_in, ci_in, input busy, done, sum, cry);
  modport slave (input start, a_in, b_in, ci_in, output busy, done, sum, cry);
endinterface

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder, LSB first, one full adder reused over WIDTH cycles.
module fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_add_ctrl #(parameter int WIDTH = 8) (
  input logic clk,
  input logic rst_n,
  serial_add_ctrl_if.slave io
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, ps_q, ps_d, sum_q, sum_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic c_q, c_d, cry_q, cry_d, busy_q, busy_d, done_q, done_d;
  logic fa_s, fa_co, accept, run, last;
  fa u_fa (.a(a_q[0]), .b(b_q[0]), .ci(c_q), .s(fa_s), .co(fa_co));
  always_comb begin
    accept  = state_q == IDLE && io.start;
    run     = state_q == RUN;
    last    = run && cnt_q == CW'(WIDTH - 1);
    state_d = accept ? RUN : last ? DONE : run ? RUN : IDLE;
    a_d     = accept ? io.a_in : run ? a_q >> 1 : a_q;
    b_d     = accept ? io.b_in : run ? b_q >> 1 : b_q;
    c_d     = accept ? io.ci_in : run ? fa_co : c_q;
    ps_d    = run ? {fa_s, ps_q[WIDTH-1:1]} : ps_q;
    // counter holds on the final bit so it never wraps inside RUN
    cnt_d   = accept ? '0 : (run && !last) ? cnt_q + CW'(1) : cnt_q;
    sum_d   = last ? ps_d : sum_q;
    cry_d   = last ? fa_co : cry_q;
    busy_d  = state_d == RUN;
    done_d  = state_d == DONE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      ps_q    <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cry_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      ps_q    <= ps_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cry_q   <= cry_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end
  assign io.busy = busy_q;
  assign io.done = done_q;
  assign io.sum  = sum_q;
  assign io.cry  = cry_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: 8- and 16-bit instances driven in lockstep, checked against a+b+ci.
module tb_serial_add_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [8:0] prev8 = '0;
  logic [16:0] prev16 = '0;
  serial_add_ctrl_if #(.WIDTH(8)) i8 ();
  serial_add_ctrl_if #(.WIDTH(16)) i16 ();
  serial_add_ctrl #(.WIDTH(8)) u8 (.clk(clk), .rst_n(rst_n), .io(i8));
  serial_add_ctrl #(.WIDTH(16)) u16 (.clk(clk), .rst_n(rst_n), .io(i16));
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic ci;
    logic [8:0] e8;
    logic [16:0] e16;
  } vec_t;
  vec_t vecs[8];

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", n, act, exp, $time);
    end
  endtask

  task automatic drive(input logic s, input logic [15:0] a, input logic [15:0] b, input logic ci);
    i8.start = s; i16.start = s;
    i8.a_in = a[7:0]; i16.a_in = a;
    i8.b_in = b[7:0]; i16.b_in = b;
    i8.ci_in = ci; i16.ci_in = ci;
  endtask

  // start at the current negedge, then follow both instances for 18 cycles
  task automatic op(input logic [15:0] a, input logic [15:0] b, input logic ci,
                    input logic [8:0] e8, input logic [16:0] e16, input bit mess);
    drive(1'b1, a, b, ci);
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      chk("busy8", 32'(i8.busy), 32'(k >= 1 && k <= 8));
      chk("done8", 32'(i8.done), 32'(k == 9));
      chk("busy16", 32'(i16.busy), 32'(k >= 1 && k <= 16));
      chk("done16", 32'(i16.done), 32'(k == 17));
      chk("never_both8", 32'(i8.busy & i8.done), 32'd0);
      chk("res8", 32'({i8.cry, i8.sum}), 32'(k >= 9 ? e8 : prev8));
      chk("res16", 32'({i16.cry, i16.sum}), 32'(k >= 17 ? e16 : prev16));
      if (mess) drive(k <= 9 ? 1'($urandom) : 1'b0, 16'($urandom), 16'($urandom), 1'($urandom));
      else drive(1'b0, a, b, ci);
    end
    prev8 = e8;
    prev16 = e16;
  endtask

  initial begin
    logic [15:0] ra[40], rb[40];
    logic rc[40];
    logic [15:0] a, b;
    logic ci;
    vecs[0] = '{16'h005A, 16'h003C, 1'b0, 9'h096, 17'h00096};
    vecs[1] = '{16'h00FF, 16'h0001, 1'b0, 9'h100, 17'h00100};
    vecs[2] = '{16'h00FF, 16'h00FF, 1'b1, 9'h1FF, 17'h001FF};
    vecs[3] = '{16'hFFFF, 16'h0001, 1'b0, 9'h100, 17'h10000};
    vecs[4] = '{16'h0000, 16'h0000, 1'b1, 9'h001, 17'h00001};
    vecs[5] = '{16'h8080, 16'h8080, 1'b0, 9'h100, 17'h10100};
    vecs[6] = '{16'h7F7F, 16'h0101, 1'b1, 9'h081, 17'h08081};
    vecs[7] = '{16'hFFFF, 16'hFFFF, 1'b1, 9'h1FF, 17'h1FFFF};
    drive(1'b1, 16'hFFFF, 16'hFFFF, 1'b1);
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'({i8.busy, i16.busy}), 32'd0);
    chk("rst_done", 32'({i8.done, i16.done}), 32'd0);
    chk("rst_res8", 32'({i8.cry, i8.sum}), 32'd0);
    chk("rst_res16", 32'({i16.cry, i16.sum}), 32'd0);
    rst_n = 1'b1;
    drive(1'b0, 16'h0, 16'h0, 1'b0);
    @(negedge clk);
    for (int i = 0; i < 8; i++)
      op(vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].e8, vecs[i].e16, i[0]);
    // start held high: 8-bit accepts every 10 cycles, operand churn ignored
    for (int i = 0; i < 40; i++) begin
      if (i > 0) @(negedge clk);
      chk("held_busy8", 32'(i8.busy), 32'(i % 10 >= 1 && i % 10 <= 8));
      chk("held_done8", 32'(i8.done), 32'(i % 10 == 9));
      if (i % 10 == 9)
        chk("held_res8", 32'({i8.cry, i8.sum}), 32'({1'b0, ra[i-9][7:0]} + {1'b0, rb[i-9][7:0]} + 9'(rc[i-9])));
      ra[i] = 16'($urandom); rb[i] = 16'($urandom); rc[i] = 1'($urandom);
      drive(1'b1, ra[i], rb[i], rc[i]);
    end
    @(negedge clk);
    drive(1'b0, 16'h0, 16'h0, 1'b0);
    repeat (20) @(negedge clk);
    // abort after 4 RUN cycles, with start coincident with reset
    drive(1'b1, 16'h005A, 16'h003C, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk("pre_abort_busy8", 32'(i8.busy), 32'd1);
      drive(1'b0, 16'h0, 16'h0, 1'b0);
    end
    rst_n = 1'b0;
    drive(1'b1, 16'h1234, 16'h4321, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 16'h0, 16'h0, 1'b0);
    chk("abort_busy", 32'({i8.busy, i16.busy}), 32'd0);
    chk("abort_done", 32'({i8.done, i16.done}), 32'd0);
    chk("abort_res8", 32'({i8.cry, i8.sum}), 32'd0);
    chk("abort_res16", 32'({i16.cry, i16.sum}), 32'd0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("abort_quiet", 32'({i8.busy, i8.done, i16.busy, i16.done}), 32'd0);
    end
    prev8 = '0;
    prev16 = '0;
    op(16'h0001, 16'h0002, 1'b1, 9'h004, 17'h00004, 1'b0);
    for (int n = 0; n < 1000; n++) begin
      a = 16'($urandom); b = 16'($urandom); ci = 1'($urandom);
      op(a, b, ci, {1'b0, a[7:0]} + {1'b0, b[7:0]} + 9'(ci), {1'b0, a} + {1'b0, b} + 17'(ci), 1'b1);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 SHALL have parameter: WIDTH, default 8, operand width in bits (legal range 2..32).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port: start  input  1  request a new addition; sampled only in IDLE.
REQ-005 SHALL have port: a_in  input  WIDTH  operand A, captured when start is accepted.
REQ-006 SHALL have port: b_in  input  WIDTH  operand B, captured when start is accepted.
REQ-007 SHALL have port: ci_in  input  1  carry-in, captured when start is accepted.
REQ-008 SHALL have port: busy  output  1  high while bits are being added (RUN).
REQ-009 SHALL have port: done  output  1  one-cycle pulse; result valid.
REQ-010 SHALL have port: sum  output  WIDTH  registered sum of the last completed addition.
REQ-011 SHALL have port: cry  output  1  registered carry-out of the last completed addition.

Function
REQ-012 SHALL compute {cry,sum} = a_in + b_in + ci_in, bit-serially, LSB first, using exactly one instance of the team's fa full-adder module.
REQ-013 SHALL implement FSM states IDLE, RUN, DONE; encoding at implementer's discretion.
REQ-014 IDLE: start=1 -> capture a_in/b_in into shift registers, ci_in into carry register, clear bit counter to 0, go RUN; start=0 -> stay IDLE.
REQ-015 RUN: each cycle feed operand LSBs and carry register to fa; shift fa sum bit into partial-sum register at MSB end; load fa carry into carry register; shift operands right; increment counter.
REQ-016 RUN -> DONE on the cycle the counter reaches WIDTH-1 (i.e. after exactly WIDTH RUN cycles).
REQ-017 On RUN->DONE transition, sum SHALL load the complete partial sum and cry the final carry.
REQ-018 DONE: done=1 for exactly one cycle, then unconditionally go IDLE.
REQ-019 Latency: start sampled high in IDLE at edge T -> done high during cycle following edge T+WIDTH; minimum start-to-start spacing WIDTH+2 cycles.
REQ-020 busy SHALL be 1 exactly in RUN; done exactly in DONE; never both high.
REQ-021 start in RUN or DONE SHALL be ignored (not queued); a_in/b_in/ci_in changes after capture SHALL not affect the result.
REQ-022 sum/cry SHALL hold their value through IDLE and during a following RUN until the next RUN->DONE load.
REQ-023 Counter width SHALL be ceil(log2(WIDTH)) bits minimum; no wrap-around may occur within RUN.

Reset
REQ-024 rst_n=0 at a rising edge SHALL force state IDLE, busy=0, done=0, sum=0, cry=0, clear counter, shift and carry registers.
REQ-025 Reset asserted mid-RUN or in DONE SHALL abort the operation with no done pulse and no update of sum/cry other than clearing.
REQ-026 start coincident with rst_n=0 SHALL be ignored.

Verification
REQ-027 WIDTH=8, a=0x5A, b=0x3C, ci=0, start pulse -> busy high 8 cycles, done one cycle, sum=0x96, cry=0.
REQ-028 a=0xFF, b=0x01, ci=0 -> sum=0x00, cry=1; a=0xFF, b=0xFF, ci=1 -> sum=0xFF, cry=1.
REQ-029 start held high continuously -> operations start every 10 cycles (WIDTH+2); operands changed during RUN do not alter the result.
REQ-030 rst_n low for one cycle after 4 RUN cycles -> next cycle IDLE, busy=0, sum=0, cry=0, no done; following start with a=0x01, b=0x02, ci=1 -> sum=0x04, cry=0.
REQ-031 Random regression, 1000 operations, WIDTH=8 and WIDTH=16 -> {cry,sum} matches a+b+ci every time; done/busy timing per REQ-019/REQ-020.
